// File: rtl/nios2_sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios2_sram_pkg                                                             |
// | Shared types and constants for the SRAM writer slave and its FIFO.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package nios2_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_IRQ       = 4;
  localparam int STAT_LEVEL_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/nios2_sram_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios2_sram_wr_fifo                                                         |
// | Synchronous FIFO with push/pop/flush; DEPTH must be a power of two >= 2.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nios2_sram_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios2_sram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios2_sram_writer                                                          |
// | Avalon-MM slave: FIFO-buffered writes to a 16-bit SRAM, auto-increment.    |
// | Optional macro NIOS2_SRAM_WRITER_IRQ_EN adds the irq port and irq_mask.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module nios2_sram_writer
  import nios2_sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 20,
  parameter int WE_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
`ifdef NIOS2_SRAM_WRITER_IRQ_EN
  output logic              irq,
`endif
  output logic              sram_oe_n
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(WE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WE_CYCLES - 1);

  wr_state_t         state;
  wr_state_t         state_next;
  logic [CNT_W-1:0]  strobe_cnt;
  logic [ADDR_W-1:0] ptr;
  logic              overflow;
  logic [15:0]       fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              reg_wr;
  logic              data_wr;
  logic              addr_wr;
  logic              status_wr;
  logic              ctrl_wr;
  logic              flush;
  logic              pop;
  logic              busy;
  logic [31:0]       rd_mux;

  assign reg_wr    = chipselect & ~write_n;
  assign data_wr   = reg_wr & (address == REG_DATA);
  assign addr_wr   = reg_wr & (address == REG_ADDR);
  assign status_wr = reg_wr & (address == REG_STATUS);
  assign ctrl_wr   = reg_wr & (address == REG_CTRL);
  assign flush     = ctrl_wr & writedata[0];
  // The word is taken from the FIFO on the edge that enters SETUP.
  assign pop       = (state_next == ST_SETUP);
  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign sram_oe_n = 1'b1;

  generate
    if (ADDR_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^writedata[31:ADDR_W];
    end
  endgenerate

  nios2_sram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (data_wr),
    .wr_data (writedata[15:0]),
    .pop     (pop),
    .flush   (flush),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: if (strobe_cnt == STROBE_LAST) state_next = ST_HOLD;
      ST_HOLD:   state_next = fifo_empty ? ST_IDLE : ST_SETUP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_ADDR: rd_mux[ADDR_W-1:0] = ptr;
      REG_STATUS: begin
        rd_mux[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
        rd_mux[STAT_BUSY]           = busy;
        rd_mux[STAT_OVERFLOW]       = overflow;
        rd_mux[STAT_FULL]           = fifo_full;
        rd_mux[STAT_EMPTY]          = fifo_empty;
`ifdef NIOS2_SRAM_WRITER_IRQ_EN
        rd_mux[STAT_IRQ]            = irq;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  // SRAM pins are registered from the state being entered, so they change
  // exactly on the state boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_cnt <= '0;
      ptr        <= '0;
      overflow   <= 1'b0;
      sram_addr  <= '0;
      sram_dq    <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      readdata   <= '0;
    end else begin
      readdata   <= rd_mux;
      strobe_cnt <= (state == ST_STROBE) ? strobe_cnt + CNT_W'(1) : '0;

      if (state == ST_STROBE && state_next == ST_HOLD)
        ptr <= ptr + ADDR_W'(1);
      else if (addr_wr && state == ST_IDLE && fifo_empty)
        ptr <= writedata[ADDR_W-1:0];

      if (data_wr && fifo_full && !pop)
        overflow <= 1'b1;
      else if (status_wr && writedata[0])
        overflow <= 1'b0;

      case (state_next)
        ST_SETUP: begin
          sram_addr  <= ptr;
          sram_dq    <= fifo_rd_data;
          sram_dq_oe <= 1'b1;
          sram_ce_n  <= 1'b0;
          sram_we_n  <= 1'b1;
        end
        ST_STROBE: sram_we_n <= 1'b0;
        ST_HOLD:   sram_we_n <= 1'b1;
        default: begin
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_we_n  <= 1'b1;
        end
      endcase
    end
  end

`ifdef NIOS2_SRAM_WRITER_IRQ_EN
  logic irq_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_mask <= writedata[1];
      if (state == ST_HOLD && state_next == ST_IDLE && irq_mask)
        irq <= 1'b1;
      else if (status_wr)
        irq <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios2_sram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nios2_sram_writer                                                       |
// | Self-checking bench: vector table, directed corner cases, random bursts.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_nios2_sram_writer;

  localparam int AW      = 20;
  localparam int WE      = 2;
  localparam int WE_SLOW = 64;
  localparam logic [1:0] A_DATA = 2'd0, A_ADDR = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            low;
    int            start;
    bit            ok;
  } wr_ev_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] start;
    logic [15:0]   data;
    int            n;
    logic [AW-1:0] exp_ptr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic cs_m = 1'b0;
  logic cs_s = 1'b0;

  logic [31:0] rd_m, rd_s;
  logic [AW-1:0] sa_m, sa_s;
  logic [15:0] dq_m, dq_s;
  logic oe_m, ce_m, we_m, oen_m;
  logic unused_oe_s, unused_ce_s, unused_oen_s, we_s;
`ifdef NIOS2_SRAM_WRITER_IRQ_EN
  logic irq_m, unused_irq_s;
`endif

  always #5 clk = ~clk;

  nios2_sram_writer #(.FIFO_DEPTH(8), .ADDR_W(AW), .WE_CYCLES(WE)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_m), .write_n(write_n),
    .writedata(writedata), .readdata(rd_m), .sram_addr(sa_m), .sram_dq(dq_m),
    .sram_dq_oe(oe_m), .sram_ce_n(ce_m), .sram_we_n(we_m),
`ifdef NIOS2_SRAM_WRITER_IRQ_EN
    .irq(irq_m),
`endif
    .sram_oe_n(oen_m)
  );

  nios2_sram_writer #(.FIFO_DEPTH(8), .ADDR_W(AW), .WE_CYCLES(WE_SLOW)) dut_slow (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_s), .write_n(write_n),
    .writedata(writedata), .readdata(rd_s), .sram_addr(sa_s), .sram_dq(dq_s),
    .sram_dq_oe(unused_oe_s), .sram_ce_n(unused_ce_s), .sram_we_n(we_s),
`ifdef NIOS2_SRAM_WRITER_IRQ_EN
    .irq(unused_irq_s),
`endif
    .sram_oe_n(unused_oen_s)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  wr_ev_t seen_q[$];
  exp_t exp_q[$];
  logic [AW-1:0] model_ptr = '0;
  int slow_cnt = 0, slow_low = 0;
  logic [AW-1:0] slow_addr = '0;
  logic [15:0] slow_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM bus observer: records one event per write strobe with its timing quality.
  initial begin : mon_main
    int low;
    wr_ev_t ev;
    logic p_ce, p_we, p_oe;
    logic [AW-1:0] p_addr;
    logic [15:0] p_dq;
    low = 0; p_ce = 1'b1; p_we = 1'b1; p_oe = 1'b0; p_addr = '0; p_dq = '0;
    ev = '{addr: '0, data: '0, low: 0, start: 0, ok: 1'b0};
    forever begin
      @(negedge clk);
      if (we_m === 1'b0) begin
        if (low == 0) begin
          ev.addr = sa_m; ev.data = dq_m; ev.start = cyc; ev.low = 0;
          ev.ok = (p_ce === 1'b0) && (p_we === 1'b1) && (p_oe === 1'b1) &&
                  (p_addr === sa_m) && (p_dq === dq_m);
        end
        if (!(ce_m === 1'b0 && oe_m === 1'b1 && sa_m === ev.addr && dq_m === ev.data)) ev.ok = 1'b0;
        low++;
      end else if (low != 0) begin
        if (!(ce_m === 1'b0 && oe_m === 1'b1 && sa_m === ev.addr && dq_m === ev.data)) ev.ok = 1'b0;
        ev.low = low;
        seen_q.push_back(ev);
        low = 0;
      end
      p_ce = ce_m; p_we = we_m; p_oe = oe_m; p_addr = sa_m; p_dq = dq_m;
    end
  end

  initial begin : mon_slow
    int low;
    low = 0;
    forever begin
      @(negedge clk);
      if (we_s === 1'b0) begin
        if (low == 0) begin slow_addr = sa_s; slow_data = dq_s; end
        low++;
      end else if (low != 0) begin
        slow_cnt++; slow_low = low; low = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input bit slow, input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    if (slow) cs_s = 1'b1; else cs_m = 1'b1;
    @(posedge clk); #1;
    cs_m = 1'b0; cs_s = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input bit slow, input logic [1:0] a, output logic [31:0] d);
    address = a; write_n = 1'b1;
    if (slow) cs_s = 1'b1; else cs_m = 1'b1;
    @(posedge clk); #1;
    d = slow ? rd_s : rd_m;
    cs_m = 1'b0; cs_s = 1'b0;
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    bus_write(1'b0, A_ADDR, {12'd0, a});
    model_ptr = a;
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_t e;
    bus_write(1'b0, A_DATA, {16'd0, w});
    e.addr = model_ptr; e.data = w;
    exp_q.push_back(e);
    model_ptr = model_ptr + 20'd1;
  endtask

  task automatic wait_idle(input bit slow, input int limit, input string tag);
    logic [31:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      bus_read(slow, A_STATUS, st);
      if (st[3] == 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s idle: busy still 1 after %0d polls, required 0", tag, limit);
    end
  endtask

  task automatic compare_writes(input string tag, input bit spacing);
    int n;
    check({tag, " nwrites"}, 64'(seen_q.size()), 64'(exp_q.size()));
    n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s w%0d addr/data", tag, i),
            {28'd0, seen_q[i].addr, seen_q[i].data}, {28'd0, exp_q[i].addr, exp_q[i].data});
      check($sformatf("%s w%0d we_low", tag, i), 64'(seen_q[i].low), 64'(WE));
      check($sformatf("%s w%0d pin timing", tag, i), 64'(seen_q[i].ok), 64'd1);
      if (spacing && i > 0)
        check($sformatf("%s w%0d spacing", tag, i),
              64'(seen_q[i].start - seen_q[i-1].start), 64'(WE + 2));
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    vec_t vecs[4];
    logic [31:0] rd;
    logic [AW-1:0] start;
    int n, gap;
    bit found;

    vecs[0] = '{start: 20'h00100, data: 16'hA5A5, n: 1, exp_ptr: 20'h00101};
    vecs[1] = '{start: 20'hFFFFF, data: 16'h1234, n: 2, exp_ptr: 20'h00001};
    vecs[2] = '{start: 20'h00000, data: 16'h0001, n: 8, exp_ptr: 20'h00008};
    vecs[3] = '{start: 20'h7FFFE, data: 16'hBEEF, n: 3, exp_ptr: 20'h80001};

    repeat (3) @(posedge clk);
    #1;
    check("reset readdata", 64'(rd_m), 64'd0);
    check("reset sram_addr", 64'(sa_m), 64'd0);
    check("reset sram_dq", 64'(dq_m), 64'd0);
    check("reset strobes {oe,ce_n,we_n,oe_n}", {60'd0, oe_m, ce_m, we_m, oen_m}, 64'b0111);
    reset = 1'b0;
    bus_read(1'b0, A_STATUS, rd);
    check("reset status", 64'(rd), 64'h1);
    bus_read(1'b0, A_ADDR, rd);
    check("reset ptr", 64'(rd), 64'h0);

    foreach (vecs[v]) begin
      set_addr(vecs[v].start);
      for (int i = 0; i < vecs[v].n; i++) push_word(vecs[v].data + 16'(i));
      wait_idle(1'b0, 100, $sformatf("vec%0d", v));
      compare_writes($sformatf("vec%0d", v), 1'b1);
      bus_read(1'b0, A_ADDR, rd);
      check($sformatf("vec%0d ptr", v), 64'(rd), 64'(vecs[v].exp_ptr));
      bus_read(1'b0, A_STATUS, rd);
      check($sformatf("vec%0d status idle", v), 64'(rd), 64'h1);
    end

    set_addr(20'h00200);
    for (int i = 0; i < 3; i++) push_word(16'h3000 + 16'(i));
    bus_write(1'b0, A_ADDR, 32'h00000555);
    wait_idle(1'b0, 100, "addr busy");
    compare_writes("addr busy", 1'b0);
    bus_read(1'b0, A_ADDR, rd);
    check("addr busy ptr", 64'(rd), 64'(model_ptr));

    for (int r = 0; r < 6; r++) begin
      start = AW'($urandom);
      n = $urandom_range(1, 8);
      set_addr(start);
      for (int i = 0; i < n; i++) begin
        push_word(16'($urandom));
        gap = $urandom_range(0, 3);
        repeat (gap) begin @(posedge clk); #1; end
      end
      wait_idle(1'b0, 100, $sformatf("rand%0d", r));
      compare_writes($sformatf("rand%0d", r), 1'b0);
      bus_read(1'b0, A_ADDR, rd);
      check($sformatf("rand%0d ptr", r), 64'(rd), 64'(model_ptr));
    end

    // Slow instance: the first word sits in a long strobe while the FIFO fills.
    bus_write(1'b1, A_ADDR, 32'h40);
    for (int i = 0; i < 10; i++) bus_write(1'b1, A_DATA, 32'hC000 + 32'(i));
    bus_read(1'b1, A_STATUS, rd);
    check("ovf status", 64'(rd), 64'h80E);
    bus_write(1'b1, A_STATUS, 32'h1);
    bus_read(1'b1, A_STATUS, rd);
    check("ovf cleared status", 64'(rd), 64'h80A);
    bus_write(1'b1, A_CTRL, 32'h1);
    bus_read(1'b1, A_STATUS, rd);
    check("flush status", 64'(rd), 64'h9);
    wait_idle(1'b1, 200, "slow");
    check("slow nwrites", 64'(slow_cnt), 64'd1);
    check("slow addr/data", {28'd0, slow_addr, slow_data}, {28'd0, 20'h00040, 16'hC000});
    check("slow we_low", 64'(slow_low), 64'(WE_SLOW));
    bus_read(1'b1, A_ADDR, rd);
    check("slow ptr", 64'(rd), 64'h41);

`ifdef NIOS2_SRAM_WRITER_IRQ_EN
    bus_write(1'b0, A_CTRL, 32'h2);
    push_word(16'h5A5A);
    wait_idle(1'b0, 100, "irq");
    compare_writes("irq", 1'b0);
    check("irq set", 64'(irq_m), 64'd1);
    bus_read(1'b0, A_STATUS, rd);
    check("irq status", 64'(rd), 64'h11);
    bus_write(1'b0, A_STATUS, 32'h0);
    check("irq cleared", 64'(irq_m), 64'd0);
    bus_write(1'b0, A_CTRL, 32'h0);
`endif

    set_addr(20'h00300);
    push_word(16'h7777);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (we_m === 1'b0) found = 1'b1;
    end
    check("reach strobe", 64'(found), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort strobes {oe,ce_n,we_n}", {61'd0, oe_m, ce_m, we_m}, 64'b011);
    check("abort readdata", 64'(rd_m), 64'd0);
    reset = 1'b0;
    bus_read(1'b0, A_STATUS, rd);
    check("abort status", 64'(rd), 64'h1);
    bus_read(1'b0, A_ADDR, rd);
    check("abort ptr", 64'(rd), 64'h0);
    seen_q.delete();
    exp_q.delete();
    model_ptr = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
